// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Two-master to one-slave Wishbone arbiter. Master m0 is the
//                instruction-fetch port and m1 is the data port; both share
//                the unified-cache slave port. Arbitration is round-robin
//                with a registered grant. A granted master keeps the slave
//                until it is acked, aborts by dropping cyc, or is timed out
//                by the no-ACK watchdog.
//
//  Ports
//    clk, rst_n          : clock (rising edge) / asynchronous active-low reset
//    m0_* / m1_*         : master ports (cyc doubles as stb)
//      *_cyc, *_we, *_sel, *_adr, *_dat_m   in  : request and write data
//      *_dat_s, *_ack, *_err                out : read data, done, timeout
//    s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_m  out : slave request
//    s_dat_s, s_ack                             in  : slave response
//
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int ADR_W   = 16,
    parameter int DAT_W   = 128,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_cyc,
    input  logic                 m0_we,
    input  logic [DAT_W/8-1:0]   m0_sel,
    input  logic [ADR_W-1:0]     m0_adr,
    input  logic [DAT_W-1:0]     m0_dat_m,
    output logic [DAT_W-1:0]     m0_dat_s,
    output logic                 m0_ack,
    output logic                 m0_err,

    input  logic                 m1_cyc,
    input  logic                 m1_we,
    input  logic [DAT_W/8-1:0]   m1_sel,
    input  logic [ADR_W-1:0]     m1_adr,
    input  logic [DAT_W-1:0]     m1_dat_m,
    output logic [DAT_W-1:0]     m1_dat_s,
    output logic                 m1_ack,
    output logic                 m1_err,

    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [DAT_W/8-1:0]   s_sel,
    output logic [ADR_W-1:0]     s_adr,
    output logic [DAT_W-1:0]     s_dat_m,
    input  logic [DAT_W-1:0]     s_dat_s,
    input  logic                 s_ack
);

    localparam int c_sel_w = DAT_W / 8;
    localparam int c_wd_w  = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic                w_last_grant_nxt;
    logic [c_wd_w-1:0]   r_wd_cnt;
    logic [c_wd_w-1:0]   w_wd_cnt_nxt;

    logic                w_granted;
    logic                w_is_m1;
    logic                w_cyc;
    logic                w_timeout;

    // ------------------------------------------------------------------
    // Granted-master selection
    // ------------------------------------------------------------------
    assign w_granted = (r_state == GNT0) || (r_state == GNT1);
    assign w_is_m1   = (r_state == GNT1);
    assign w_cyc     = w_is_m1 ? m1_cyc : m0_cyc;

    // Watchdog fires only while the owner still holds cyc and the slave has
    // not answered this cycle: an ack in the last allowed cycle wins, and an
    // abort is never reported as an error.
    assign w_timeout = w_granted && w_cyc && !s_ack && (r_wd_cnt == c_wd_last);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // so the first contended grant goes to m0
            r_wd_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_wd_cnt_nxt     = r_wd_cnt;

        case (r_state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_state_nxt = r_last_grant ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    w_state_nxt = GNT0;
                end else if (m1_cyc) begin
                    w_state_nxt = GNT1;
                end

                if (w_state_nxt == GNT0) begin
                    w_last_grant_nxt = 1'b0;
                    w_wd_cnt_nxt     = '0;
                end else if (w_state_nxt == GNT1) begin
                    w_last_grant_nxt = 1'b1;
                    w_wd_cnt_nxt     = '0;
                end
            end

            GNT0, GNT1: begin
                // Always pass through IDLE after a transaction so the other
                // master gets a fair look at the next arbitration.
                if (s_ack || !w_cyc || w_timeout) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + c_wd_w'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slave-side outputs: copies of the owner, zero while idle
    // ------------------------------------------------------------------
    assign s_cyc   = w_granted && w_cyc;
    assign s_stb   = w_granted && w_cyc;
    assign s_we    = w_granted && (w_is_m1 ? m1_we : m0_we);
    assign s_sel   = w_granted ? (w_is_m1 ? m1_sel : m0_sel) : {c_sel_w{1'b0}};
    assign s_adr   = w_granted ? (w_is_m1 ? m1_adr : m0_adr) : {ADR_W{1'b0}};
    assign s_dat_m = w_granted ? (w_is_m1 ? m1_dat_m : m0_dat_m) : {DAT_W{1'b0}};

    // ------------------------------------------------------------------
    // Master-side outputs
    // ------------------------------------------------------------------
    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;

    assign m0_ack   = (r_state == GNT0) && s_ack;
    assign m1_ack   = (r_state == GNT1) && s_ack;
    assign m0_err   = (r_state == GNT0) && w_timeout;
    assign m1_err   = (r_state == GNT1) && w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed scoreboard bench for wb_arbiter. Stimulus pushes
//                the expected master response into a queue; a monitor pops
//                and compares whenever any ack/err is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int ADR_W   = 16;
    localparam int DAT_W   = 128;
    localparam int SEL_W   = DAT_W / 8;
    localparam int TIMEOUT = 4;

    logic             clk;
    logic             rst_n;
    logic             m0_cyc, m0_we, m1_cyc, m1_we;
    logic [SEL_W-1:0] m0_sel, m1_sel;
    logic [ADR_W-1:0] m0_adr, m1_adr;
    logic [DAT_W-1:0] m0_dat_m, m1_dat_m, m0_dat_s, m1_dat_s;
    logic             m0_ack, m1_ack, m0_err, m1_err;
    logic             s_cyc, s_stb, s_we, s_ack;
    logic [SEL_W-1:0] s_sel;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_m, s_dat_s;

    wb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
        .m0_dat_m(m0_dat_m), .m0_dat_s(m0_dat_s), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
        .m1_dat_m(m1_dat_m), .m1_dat_s(m1_dat_s), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: acks `lat` cycles after s_cyc rises, never for 0xDEAD;
    // stray_ack injects an ack regardless of s_cyc.
    int   lat;
    int   sl_cnt;
    logic stray_ack;

    always @(posedge clk) begin
        if (s_cyc && !s_ack) sl_cnt <= sl_cnt + 1;
        else                 sl_cnt <= 0;
    end

    assign s_ack = (s_cyc && (sl_cnt == lat) && (s_adr != 16'hDEAD)) || stray_ack;

    // Scoreboard
    typedef struct packed {
        logic             m;
        logic             err;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dm;
        logic [DAT_W-1:0] ds;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [DAT_W-1:0] act,
                         input logic [DAT_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack || m0_err || m1_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: ack0=%b ack1=%b err0=%b err1=%b, expected none",
                         m0_ack, m1_ack, m0_err, m1_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("m0_ack",   DAT_W'(m0_ack), DAT_W'(!mon_e.m && !mon_e.err));
                check("m1_ack",   DAT_W'(m1_ack), DAT_W'( mon_e.m && !mon_e.err));
                check("m0_err",   DAT_W'(m0_err), DAT_W'(!mon_e.m &&  mon_e.err));
                check("m1_err",   DAT_W'(m1_err), DAT_W'( mon_e.m &&  mon_e.err));
                check("m0_dat_s", m0_dat_s, mon_e.ds);
                check("m1_dat_s", m1_dat_s, mon_e.ds);
                check("s_cyc",    DAT_W'(s_cyc), DAT_W'(1));
                check("s_stb",    DAT_W'(s_stb), DAT_W'(1));
                check("s_we",     DAT_W'(s_we),  DAT_W'(mon_e.we));
                check("s_sel",    DAT_W'(s_sel), DAT_W'(mon_e.sel));
                check("s_adr",    DAT_W'(s_adr), DAT_W'(mon_e.adr));
                check("s_dat_m",  s_dat_m, mon_e.dm);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || m0_err || m1_err) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: no response within 40 cycles, expected ack or err", name);
        end
    endtask

    task automatic push(input logic m, input logic err, input logic we,
                        input logic [SEL_W-1:0] sel, input logic [ADR_W-1:0] adr,
                        input logic [DAT_W-1:0] dm, input logic [DAT_W-1:0] ds);
        exp_t e;
        e.m = m; e.err = err; e.we = we; e.sel = sel; e.adr = adr; e.dm = dm; e.ds = ds;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stray_ack = 1'b0; lat = 1; s_dat_s = '0;
        m0_cyc = 1'b1; m0_we = 1'b1; m0_sel = '1; m0_adr = 16'h1111; m0_dat_m = '1;
        m1_cyc = 1'b1; m1_we = 1'b1; m1_sel = '1; m1_adr = 16'h2222; m1_dat_m = '1;

        // Reset holds everything idle even with both masters requesting
        repeat (2) @(negedge clk);
        check("rst_s_cyc",   DAT_W'(s_cyc), '0);
        check("rst_s_we",    DAT_W'(s_we),  '0);
        check("rst_s_adr",   DAT_W'(s_adr), '0);
        check("rst_s_dat_m", s_dat_m,       '0);
        check("rst_acks",    DAT_W'({m0_ack, m1_ack, m0_err, m1_err}), '0);
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single m0 read; ack lands on the last watchdog cycle, ack must win
        lat = 3;
        s_dat_s = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D;
        m0_cyc = 1'b1; m0_we = 1'b0; m0_sel = '1; m0_adr = 16'h1230; m0_dat_m = 128'h55;
        push(1'b0, 1'b0, 1'b0, '1, 16'h1230, 128'h55, s_dat_s);
        @(negedge clk);
        check("t1_req_cycle_s_cyc", DAT_W'(s_cyc), '0);
        @(negedge clk);
        check("t1_grant_cycle_s_cyc", DAT_W'(s_cyc), DAT_W'(1));
        wait_resp("t1_resp");
        tick();
        m0_cyc = 1'b0;

        // m1 write with partial byte select
        lat = 2;
        s_dat_s = 128'hFEED;
        m1_cyc = 1'b1; m1_we = 1'b1; m1_sel = 16'hFFFC; m1_adr = 16'h0042;
        m1_dat_m = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        push(1'b1, 1'b0, 1'b1, 16'hFFFC, 16'h0042, m1_dat_m, s_dat_s);
        wait_resp("t2_resp");
        tick();
        m1_cyc = 1'b0;

        // Both masters continuous: m0,m1,m0,m1 with one idle cycle between
        lat = 1;
        s_dat_s = 128'hC0DE;
        m0_cyc = 1'b1; m0_we = 1'b0; m0_sel = 16'h00FF; m0_adr = 16'h1000; m0_dat_m = 128'h10;
        m1_cyc = 1'b1; m1_we = 1'b1; m1_sel = 16'hFF00; m1_adr = 16'h2000; m1_dat_m = 128'h20;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1'b0, 1'b0, 1'b0, 16'h00FF, 16'h1000, 128'h10, 128'hC0DE);
            else            push(1'b1, 1'b0, 1'b1, 16'hFF00, 16'h2000, 128'h20, 128'hC0DE);
        end
        for (int k = 0; k < 4; k++) begin
            wait_resp("t3_resp");
            if (k == 3) begin
                tick();
                m0_cyc = 1'b0; m1_cyc = 1'b0;
            end
            @(negedge clk);
            check("t3_idle_gap", DAT_W'(s_cyc), '0);
            if (k < 3) begin
                @(negedge clk);
                check("t3_regrant", DAT_W'(s_cyc), DAT_W'(1));
            end
        end

        // Watchdog: slave never acks m0; m1 waits and is served afterwards
        lat = 1;
        s_dat_s = 128'hBEEF;
        m0_cyc = 1'b1; m0_we = 1'b0; m0_sel = '1; m0_adr = 16'hDEAD; m0_dat_m = 128'h77;
        push(1'b0, 1'b1, 1'b0, '1, 16'hDEAD, 128'h77, 128'hBEEF);
        push(1'b1, 1'b0, 1'b0, 16'h000F, 16'h3000, 128'h88, 128'hBEEF);
        tick();
        m1_cyc = 1'b1; m1_we = 1'b0; m1_sel = 16'h000F; m1_adr = 16'h3000; m1_dat_m = 128'h88;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t4_err_timing", DAT_W'(m0_err), DAT_W'(i == 4));
            check("t4_m1_held",    DAT_W'({m1_ack, m1_err}), '0);
            check("t4_s_adr",      DAT_W'(s_adr), DAT_W'(16'hDEAD));
        end
        tick();
        m0_cyc = 1'b0;
        wait_resp("t4_m1_resp");
        tick();
        m1_cyc = 1'b0;

        // Abort: m0 drops cyc before ack, a late stray ack is ignored
        lat = 3;
        m0_cyc = 1'b1; m0_we = 1'b0; m0_adr = 16'h4444;
        @(negedge clk);
        @(negedge clk);
        check("t5_granted", DAT_W'(s_cyc), DAT_W'(1));
        tick();
        m0_cyc = 1'b0;
        @(negedge clk);
        check("t5_abort_s_cyc",   DAT_W'(s_cyc), '0);
        check("t5_abort_ack_err", DAT_W'({m0_ack, m0_err}), '0);
        tick();
        stray_ack = 1'b1;
        @(negedge clk);
        check("t5_stray_acks", DAT_W'({m0_ack, m1_ack}), '0);
        check("t5_stray_s_cyc", DAT_W'(s_cyc), '0);
        tick();
        stray_ack = 1'b0;

        // Reset in GNT1, then m0 wins the first contended grant
        lat = 3;
        s_dat_s = 128'h600D;
        m0_cyc = 1'b1; m0_we = 1'b0; m0_sel = '1; m0_adr = 16'h5000; m0_dat_m = 128'h5;
        m1_cyc = 1'b1; m1_we = 1'b0; m1_sel = '1; m1_adr = 16'h6000; m1_dat_m = 128'h6;
        @(negedge clk);
        @(negedge clk);
        check("t6_gnt1_s_adr", DAT_W'(s_adr), DAT_W'(16'h6000));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_s_cyc", DAT_W'(s_cyc), '0);
        check("t6_async_s_adr", DAT_W'(s_adr), '0);
        tick();
        tick();
        push(1'b0, 1'b0, 1'b0, '1, 16'h5000, 128'h5, 128'h600D);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_rst_idle", DAT_W'(s_cyc), '0);
        @(negedge clk);
        check("t6_first_gnt_adr", DAT_W'(s_adr), DAT_W'(16'h5000));
        wait_resp("t6_resp");
        tick();
        m0_cyc = 1'b0; m1_cyc = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_empty", DAT_W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Purpose: shares one wishbone slave port (unified cache) between two wishbone masters, m0 (instruction fetch) and m1 (data access). Round-robin arbitration, transaction lock, no-ACK watchdog.

Interface
REQ-001 Parameter: ADR_W, 16, address width.
REQ-002 Parameter: DAT_W, 128, data width; SEL width SHALL be DAT_W/8.
REQ-003 Parameter: TIMEOUT, 64, max cycles a granted transaction waits for ACK (legal range 2..255).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 m0_cyc, m1_cyc  in  1 each  master cycle request; STB equals CYC for all masters.
REQ-008 m0_we, m1_we  in  1 each  write enable.
REQ-009 m0_sel, m1_sel  in  DAT_W/8 each  byte select.
REQ-010 m0_adr, m1_adr  in  ADR_W each  address.
REQ-011 m0_dat_m, m1_dat_m  in  DAT_W each  write data.
REQ-012 m0_dat_s, m1_dat_s  out  DAT_W each  read data.
REQ-013 m0_ack, m1_ack  out  1 each  transfer complete.
REQ-014 m0_err, m1_err  out  1 each  watchdog timeout, one-cycle pulse.
REQ-015 s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe and write enable.
REQ-016 s_sel  out  DAT_W/8  slave byte select.
REQ-017 s_adr  out  ADR_W  slave address.
REQ-018 s_dat_m  out  DAT_W  slave write data.
REQ-019 s_dat_s  in  DAT_W  slave read data.
REQ-020 s_ack  in  1  slave acknowledge.

Function
REQ-021 FSM states SHALL be IDLE, GNT0 and GNT1; a 1-bit last_grant register and a watchdog counter wd_cnt of ceil(log2(TIMEOUT+1)) bits SHALL be kept.
REQ-022 In IDLE with exactly one mX_cyc high, the next state SHALL be GNTX.
REQ-023 In IDLE with both requesting, the next state SHALL be GNT0 if last_grant=1, else GNT1.
REQ-024 On entering GNTX, last_grant SHALL load X and wd_cnt SHALL load 0.
REQ-025 Grant is registered: a request first seen in IDLE at cycle N SHALL produce s_cyc=1 in cycle N+1.
REQ-026 In GNTX, s_cyc=s_stb=mX_cyc, and s_we/s_sel/s_adr/s_dat_m SHALL be combinational copies of master X; in IDLE all s_* outputs SHALL be 0.
REQ-027 s_dat_s SHALL drive both mX_dat_s unconditionally; mX_ack SHALL equal s_ack only while in GNTX, otherwise 0.
REQ-028 In GNTX, s_ack=1 SHALL return the FSM to IDLE in the next cycle, giving exactly one idle cycle between back-to-back transactions.
REQ-029 In GNTX, mX_cyc=0 with s_ack=0 (abort) SHALL return the FSM to IDLE in the next cycle without an ack or err.
REQ-030 In GNTX, wd_cnt SHALL increment each cycle without s_ack; when wd_cnt=TIMEOUT-1 and s_ack=0, mX_err SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-031 When s_ack and the timeout condition coincide, the ack SHALL win and err SHALL stay 0.
REQ-032 The non-granted master's request SHALL be held off (no ack, no err) and SHALL not lose its turn.
REQ-033 s_ack received in IDLE SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, last_grant=1, wd_cnt=0 and all outputs to 0, including mid-transaction.
REQ-035 After rst_n rises, the first grant with both masters requesting SHALL go to m0.

Verification
REQ-036 Single m0 read, adr=0x1230, slave acks 3 cycles after s_cyc -> s_cyc high in cycle 1, m0_ack one pulse, m1_ack=0, m0_dat_s=s_dat_s.
REQ-037 Both masters request continuously, slave acks in 1 cycle -> grant order m0,m1,m0,m1, with one IDLE cycle between each.
REQ-038 m1 write sel=0xFFFC, adr=0x0042 while m0 idle -> s_we=1, s_sel=0xFFFC, s_adr=0x0042, s_dat_m=m1_dat_m.
REQ-039 TIMEOUT=4, slave never acks for m0 -> m0_err pulses in the 4th granted cycle, FSM returns to IDLE, pending m1 is granted next.
REQ-040 rst_n dropped during GNT1 -> s_cyc=0 in the same cycle; after release with both requesting, m0 is granted first.
REQ-041 m0 drops cyc before ack -> IDLE next cycle, m0_ack=m0_err=0, s_ack arriving later is ignored.
